instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields (format, opcode, registers, 64-bit immediate) into 32-bit LEGv8 words and writes them sequentially into instruction memory. It is the inverse of the CPU's immediate sign extension. The bench loader and the self-test program generator use it to build program images for the single-cycle CPU. Every immediate is range-checked: the 64-bit value must equal the sign-extension of the field that will hold it, or the word is rejected.

## Interface
Parameters:
- `ADDR_W`, 6: instruction memory word-address width; depth is 2**ADDR_W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  field set presented.
- `in_ready`  out  1  encoder can accept a field set.
- `fmt`  in  2  instruction format: 0 B, 1 CBZ, 2 CBNZ, 3 D.
- `opcode`  in  11  D-format opcode, bits [31:21]; ignored for other formats.
- `rn`  in  5  base register (D only).
- `rt`  in  5  target register (CBZ/CBNZ/D).
- `imm`  in  64  signed immediate, in the units of the field (word offset for B/CB, byte offset for D).
- `restart`  in  1  synchronous; returns write address to 0.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  encoded instruction.
- `range_err`  out  1  one-cycle pulse when an immediate does not fit.
- `full`  out  1  all memory words written.
- `count`  out  ADDR_W+1  number of words written since reset or restart.

## Operation
- States: IDLE, PACK, WRITE, FULL. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is high, latch all fields and go to PACK.
- PACK:
  - Compute the word and the range check from the latched fields.
  - If the immediate fits: register the word into `mem_wdata` and go to WRITE.
  - If it does not fit: pulse `range_err` for the next cycle, leave the address unchanged, go to IDLE.
- WRITE:
  - `mem_we`=1 for exactly one cycle at `mem_addr`.
  - Then increment address and `count`.
  - If the address just written was 2**ADDR_W-1, go to FULL with `full`=1; otherwise go to IDLE.
- FULL:
  - `in_ready`=0.
  - Hold until `restart`.
- Encodings:
  - B: {6'b000101, imm[25:0]}.
  - CBZ: {8'b10110100, imm[18:0], rt}.
  - CBNZ: {8'b10110101, imm[18:0], rt}.
  - D: {opcode, imm[8:0], 2'b00, rn, rt}.
- Range rule: N = 26 (B), 19 (CB) or 9 (D). The immediate fits when imm[63:N-1] is all zeros or all ones.
- `restart`:
  - Has priority in every state.
  - Next state is IDLE; address, `count` and `full` clear.
  - Any in-flight field set is dropped: no write and no `range_err`.
- Reset mid-operation: all outputs drop immediately; the in-flight instruction is lost.
- Reset values: `in_ready`=0 while `reset_n` is low and 1 in IDLE after it releases. `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `range_err`=0, `full`=0, `count`=0.

## Timing
- Handshake completes at the edge where `in_valid`&&`in_ready` (E0).
- PACK occupies cycle E0..E1. `mem_we` is high during cycle E1..E2, and the memory captures the word at E2.
- `in_ready` is high again after E2. Throughput is one word per 3 cycles.
- `range_err` is high during cycle E1..E2. `in_ready` returns after E2, so the error and accept paths have equal latency.
- `mem_addr` and `mem_wdata` are stable throughout the `mem_we` cycle.
- `in_ready` is a registered output with no combinational path from `in_valid`.

## Structure
- Shared package `legv8_pkg` holds:
  - the `fmt` enum;
  - the B/CBZ/CBNZ opcode constants;
  - LDUR (11'b11111000010) and STUR (11'b11111000000);
  - field widths 26/19/9;
  - the state enum.
- One sub-module, `imm_range_check`: combinational; inputs `imm` and field width N, output `fits`.
- The top holds the FSM, the field latch, the address and count registers, and the packing mux.

## Test plan
- B, imm=-4 -> `mem_wdata`=0x17FFFFFC at address 0; `mem_we` high for exactly one cycle, 2 cycles after the handshake.
- CBZ, rt=3, imm=2 -> 0xB4000043 at address 1; CBNZ with the same fields -> 0xB5000043.
- D, LDUR, rt=1, rn=2, imm=-8 -> 0xF85F8041.
- D, imm=256 -> `range_err` one-cycle pulse, no `mem_we`, `count` unchanged. Then imm=-256 is accepted with DT field 0x100. B with imm=2**25 is rejected.
- ADDR_W=2, write 4 words -> `full`=1, `in_ready`=0, `count`=4, further `in_valid` ignored. Then `restart` -> `mem_addr`=0, `full`=0, `in_ready`=1.
- `reset_n` low during WRITE -> `mem_we` drops the same cycle. `restart` during PACK -> no write, no `range_err`, IDLE next.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 formats, opcodes, field widths and encoder states
package legv8_pkg;
    typedef enum logic [1:0] {FMT_B, FMT_CBZ, FMT_CBNZ, FMT_D} fmt_t;
    typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_FULL} state_t;
    localparam logic [5:0] OP_B = 6'b000101;
    localparam logic [7:0] OP_CBZ = 8'b10110100;
    localparam logic [7:0] OP_CBNZ = 8'b10110101;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [6:0] W_B = 7'd26;
    localparam logic [6:0] W_CB = 7'd19;
    localparam logic [6:0] W_D = 7'd9;
endpackage

// File: rtl/imm_range_check.sv
// imm_range_check: does a 64-bit immediate sign-extend from an n-bit field
module imm_range_check (
    input  logic [63:0] imm,
    input  logic [6:0]  n,
    output logic        fits
);
    logic [63:0] hi;
    assign hi = $signed(imm) >>> (n - 7'd1);
    assign fits = (hi == '0) || (hi == '1);
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into LEGv8 words and writes them to instruction memory
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [10:0]       opcode,
    input  logic [4:0]        rn,
    input  logic [4:0]        rt,
    input  logic [63:0]       imm,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              range_err,
    output logic              full,
    output logic [ADDR_W:0]   count
);
    state_t      state;
    fmt_t        fmt_q;
    logic [10:0] opcode_q;
    logic [4:0]  rn_q, rt_q;
    logic [63:0] imm_q;
    logic [6:0]  n;
    logic        fits;
    logic [31:0] word;

    assign n = fmt_q == FMT_B ? W_B : fmt_q == FMT_D ? W_D : W_CB;
    assign word = fmt_q == FMT_B    ? {OP_B, imm_q[25:0]} :
                  fmt_q == FMT_CBZ  ? {OP_CBZ, imm_q[18:0], rt_q} :
                  fmt_q == FMT_CBNZ ? {OP_CBNZ, imm_q[18:0], rt_q} :
                                      {opcode_q, imm_q[8:0], 2'b00, rn_q, rt_q};

    imm_range_check u_chk (.imm(imm_q), .n(n), .fits(fits));

    // Accept -> pack/check -> write one word, with restart overriding everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            range_err <= 1'b0;
            full      <= 1'b0;
            count     <= '0;
            fmt_q     <= FMT_B;
            opcode_q  <= '0;
            rn_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
        end else if (restart) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            range_err <= 1'b0;
            mem_addr  <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    range_err <= 1'b0;
                    if (in_valid && in_ready) begin
                        fmt_q    <= fmt_t'(fmt);
                        opcode_q <= opcode;
                        rn_q     <= rn;
                        rt_q     <= rt;
                        imm_q    <= imm;
                        in_ready <= 1'b0;
                        state    <= S_PACK;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_PACK: begin
                    if (fits) begin
                        mem_wdata <= word;
                        mem_we    <= 1'b1;
                        state     <= S_WRITE;
                    end else begin
                        range_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    mem_we   <= 1'b0;
                    mem_addr <= mem_addr + 1'b1;
                    count    <= count + 1'b1;
                    if (&mem_addr) begin
                        full  <= 1'b1;
                        state <= S_FULL;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: in_ready <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for instr_encoder with a 4-word memory
module tb_instr_encoder;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [1:0]  fmt = 0;
    logic [10:0] opcode = 0;
    logic [4:0]  rn = 0;
    logic [4:0]  rt = 0;
    logic [63:0] imm = 0;
    logic        restart = 0;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        range_err;
    logic        full;
    logic [2:0]  count;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;

    instr_encoder #(.ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rn(rn), .rt(rt), .imm(imm), .restart(restart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .range_err(range_err), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] f, input logic [10:0] op, input logic [4:0] b,
                        input logic [4:0] t, input logic [63:0] im, input logic err,
                        input logic [31:0] w, input logic [1:0] a);
        @(negedge clk);
        check("ready_before", in_ready, 1);
        in_valid = 1; fmt = f; opcode = op; rn = b; rt = t; imm = im;
        @(negedge clk);
        in_valid = 0;
        check("pack_we", mem_we, 0);
        check("pack_ready", in_ready, 0);
        @(negedge clk);
        if (err) begin
            check("err_pulse", range_err, 1);
            check("err_no_we", mem_we, 0);
            check("err_ready", in_ready, 0);
        end else begin
            check("we", mem_we, 1);
            check("wdata", mem_wdata, w);
            check("addr", mem_addr, a);
            check("no_err", range_err, 0);
        end
        @(negedge clk);
        check("we_done", mem_we, 0);
        check("err_done", range_err, 0);
    endtask

    initial begin
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_err", range_err, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        @(negedge clk); reset_n = 1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        // restart during PACK drops the field set
        in_valid = 1; fmt = 2'd3; opcode = LDUR; rn = 2; rt = 1; imm = 64'd300;
        @(negedge clk);
        in_valid = 0; restart = 1;
        @(negedge clk);
        restart = 0;
        check("rs_pack_we", mem_we, 0);
        check("rs_pack_err", range_err, 0);
        check("rs_pack_ready", in_ready, 1);
        @(negedge clk);
        check("rs_pack_we2", mem_we, 0);
        check("rs_pack_err2", range_err, 0);
        check("rs_pack_count", count, 0);
        // accepted and rejected words
        xfer(2'd0, 0, 0, 0, -64'sd4, 0, 32'h17FFFFFC, 2'd0);
        check("count1", count, 1);
        xfer(2'd3, STUR, 0, 0, 64'd256, 1, 0, 0);
        check("count_after_err", count, 1);
        check("addr_after_err", mem_addr, 1);
        xfer(2'd0, 0, 0, 0, 64'h0000_0000_0200_0000, 1, 0, 0);
        check("count_after_berr", count, 1);
        xfer(2'd1, 0, 0, 5'd3, 64'd2, 0, 32'hB4000043, 2'd1);
        xfer(2'd2, 0, 0, 5'd3, 64'd2, 0, 32'hB5000043, 2'd2);
        xfer(2'd3, LDUR, 5'd2, 5'd1, -64'sd8, 0, 32'hF85F8041, 2'd3);
        check("full", full, 1);
        check("full_ready", in_ready, 0);
        check("full_count", count, 4);
        // full: input ignored
        in_valid = 1; fmt = 2'd0; imm = 64'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_we", mem_we, 0);
            check("full_hold_count", count, 4);
        end
        in_valid = 0; restart = 1;
        @(negedge clk);
        restart = 0;
        check("restart_addr", mem_addr, 0);
        check("restart_full", full, 0);
        check("restart_count", count, 0);
        check("restart_ready", in_ready, 1);
        xfer(2'd3, STUR, 0, 0, -64'sd256, 0, 32'hF8100000, 2'd0);
        check("count_post_restart", count, 1);
        // async reset during WRITE
        @(negedge clk);
        in_valid = 1; fmt = 2'd0; imm = 64'd5;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        check("pre_rst_we", mem_we, 1);
        #2 reset_n = 0;
        #1;
        check("async_we", mem_we, 0);
        check("async_ready", in_ready, 0);
        check("async_count", count, 0);
        check("async_wdata", mem_wdata, 0);
        @(negedge clk); reset_n = 1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
